lcd_bus_reader: RTL

- Read-side companion to the HD44780 LCD write driver; executes HD44780 read cycles (RW=1).
- Reads either the busy flag/address counter (RS=0) or a data RAM byte (RS=1).
- Drives EN/RW/RS with parameterised setup, pulse, hold and cycle timing.
- Captures the LCD data bus and returns the byte with a one-cycle valid strobe; sits beside the write driver behind the board bus mux.

---
 rtl/lcd_pkg.sv | 27 ++
 rtl/lcd_phase_timer.sv | 29 ++
 rtl/lcd_bus_reader.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared HD44780 definitions: read-cycle states, RS encodings, bit positions
// and default bus timing used by both the LCD read and write drivers.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_GAP
  } state_e;

  localparam logic RS_INSTR = 1'b0;
  localparam logic RS_DATA  = 1'b1;

  localparam int BF_BIT  = 7;
  localparam int ADDR_W  = 7;
  localparam int TIMER_W = 8;

  // Cycle counts for a 50 MHz clock
  localparam int T_AS_DEF     = 2;
  localparam int T_PW_DEF     = 12;
  localparam int T_H_DEF      = 1;
  localparam int T_GAP_DEF    = 10;
  localparam int POLL_MAX_DEF = 4095;

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter that times one bus phase; done_o is high while the
// count sits at zero, so loading N-1 yields a phase of exactly N cycles.
module lcd_phase_timer #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] count_o,
  output logic         done_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign count_o = count_q;
  assign done_o  = (count_q == '0);

endmodule

// File: rtl/lcd_bus_reader.sv
// HD44780 read-cycle engine (RW=1): fetches BF/address or a data RAM byte.
// Define LCD_READER_BUSY_POLL_EN to add the repeated busy-flag poll.
module lcd_bus_reader
  import lcd_pkg::*;
#(
  parameter int T_AS_CYC  = T_AS_DEF,
  parameter int T_PW_CYC  = T_PW_DEF,
  parameter int T_H_CYC   = T_H_DEF,
  parameter int T_GAP_CYC = T_GAP_DEF,
  parameter int POLL_MAX  = POLL_MAX_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic              rs_sel_i,
  output logic              ready_o,
  output logic [7:0]        rdata_o,
  output logic              rdata_valid_o,
  output logic              busy_flag_o,
  output logic [ADDR_W-1:0] addr_cnt_o,
  input  logic              poll_req_i,
  output logic              poll_done_o,
  output logic              poll_timeout_o,
  output logic              bus_owned_o,
  input  logic [7:0]        lcd_data_in_i,
  output logic              lcd_data_oe_o,
  output logic              lcd_en_o,
  output logic              lcd_rw_o,
  output logic              lcd_rs_o
);

  if (T_AS_CYC < 1 || T_PW_CYC < 1 || T_H_CYC < 1 || T_GAP_CYC < 1 ||
      T_AS_CYC > 256 || T_PW_CYC > 256 || T_H_CYC > 256 || T_GAP_CYC > 256 ||
      POLL_MAX < 1) begin : g_bad_param
    $error("lcd_bus_reader: phase lengths must be 1..256 and POLL_MAX >= 1");
  end

  localparam logic [TIMER_W-1:0] AS_LD  = TIMER_W'(T_AS_CYC - 1);
  localparam logic [TIMER_W-1:0] PW_LD  = TIMER_W'(T_PW_CYC - 1);
  localparam logic [TIMER_W-1:0] H_LD   = TIMER_W'(T_H_CYC - 1);
  localparam logic [TIMER_W-1:0] GAP_LD = TIMER_W'(T_GAP_CYC - 1);

  state_e state_q, state_d;
  logic rs_q, rs_d, en_q, en_d, rw_q, rw_d, own_q, own_d, ready_q, ready_d;
  logic valid_q, valid_d, bf_q, bf_d;
  logic [7:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic go, goRs, tLoad, tDone, lastGapNext, pollBusy;
  logic [TIMER_W-1:0] tVal, tCount;

`ifdef LCD_READER_BUSY_POLL_EN
  localparam int PCW = $clog2(POLL_MAX + 1);
  logic polling_q, polling_d, pollDone_q, pollDone_d, pollTo_q, pollTo_d;
  logic [PCW-1:0] pollCnt_q, pollCnt_d;
`endif

  lcd_phase_timer #(.W(TIMER_W)) u_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (tLoad),
    .load_val_i (tVal),
    .count_o    (tCount),
    .done_o     (tDone)
  );

  // Ready is also raised in the last GAP cycle so a held req restarts the
  // next read without spending a cycle in IDLE.
  always_comb begin
    state_d     = state_q;
    rs_d        = rs_q;
    rdata_d     = rdata_q;
    valid_d     = 1'b0;
    bf_d        = bf_q;
    addr_d      = addr_q;
    go          = 1'b0;
    goRs        = RS_INSTR;
    tLoad       = 1'b0;
    tVal        = '0;
    pollBusy    = 1'b0;
`ifdef LCD_READER_BUSY_POLL_EN
    polling_d   = polling_q;
    pollCnt_d   = pollCnt_q;
    pollDone_d  = 1'b0;
    pollTo_d    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          go   = 1'b1;
          goRs = rs_sel_i;
        end
`ifdef LCD_READER_BUSY_POLL_EN
        else if (poll_req_i) begin
          go        = 1'b1;
          goRs      = RS_INSTR;
          polling_d = 1'b1;
          pollCnt_d = '0;
        end
`endif
      end
      ST_SETUP: if (tDone) begin
        state_d = ST_PULSE;
        tLoad   = 1'b1;
        tVal    = PW_LD;
      end
      ST_PULSE: if (tDone) begin
        state_d = ST_HOLD;
        tLoad   = 1'b1;
        tVal    = H_LD;
        rdata_d = lcd_data_in_i;
      end
      ST_HOLD: if (tDone) begin
        state_d = ST_GAP;
        tLoad   = 1'b1;
        tVal    = GAP_LD;
        valid_d = 1'b1;
        if (rs_q == RS_INSTR) begin
          bf_d   = rdata_q[BF_BIT];
          addr_d = rdata_q[ADDR_W-1:0];
        end
`ifdef LCD_READER_BUSY_POLL_EN
        if (polling_q) pollCnt_d = pollCnt_q + 1'b1;
`endif
      end
      ST_GAP: if (tDone) begin
        state_d = ST_IDLE;
`ifdef LCD_READER_BUSY_POLL_EN
        if (polling_q) begin
          if (!bf_q) begin
            pollDone_d = 1'b1;
            polling_d  = 1'b0;
          end else if (pollCnt_q == PCW'(POLL_MAX)) begin
            pollDone_d = 1'b1;
            pollTo_d   = 1'b1;
            polling_d  = 1'b0;
          end else begin
            go = 1'b1;
          end
        end else
`endif
        if (req_i) begin
          go   = 1'b1;
          goRs = rs_sel_i;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (go) begin
      state_d = ST_SETUP;
      rs_d    = goRs;
      tLoad   = 1'b1;
      tVal    = AS_LD;
    end

`ifdef LCD_READER_BUSY_POLL_EN
    pollBusy = polling_d;
`endif
    lastGapNext = (state_d == ST_GAP) &&
                  (tLoad ? (tVal == '0) : (tCount == TIMER_W'(1)));
    ready_d = (state_d == ST_IDLE) || (lastGapNext && !pollBusy);
    en_d    = (state_d == ST_PULSE);
    rw_d    = (state_d == ST_SETUP) || (state_d == ST_PULSE) || (state_d == ST_HOLD);
    own_d   = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      rs_q    <= 1'b0;
      en_q    <= 1'b0;
      rw_q    <= 1'b0;
      own_q   <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      bf_q    <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      rs_q    <= rs_d;
      en_q    <= en_d;
      rw_q    <= rw_d;
      own_q   <= own_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      bf_q    <= bf_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
    end
  end

`ifdef LCD_READER_BUSY_POLL_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      polling_q  <= 1'b0;
      pollCnt_q  <= '0;
      pollDone_q <= 1'b0;
      pollTo_q   <= 1'b0;
    end else begin
      polling_q  <= polling_d;
      pollCnt_q  <= pollCnt_d;
      pollDone_q <= pollDone_d;
      pollTo_q   <= pollTo_d;
    end
  end

  assign poll_done_o    = pollDone_q;
  assign poll_timeout_o = pollTo_q;
`else
  logic unused_poll;
  assign unused_poll    = poll_req_i;
  assign poll_done_o    = 1'b0;
  assign poll_timeout_o = 1'b0;
`endif

  assign ready_o       = ready_q;
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = valid_q;
  assign busy_flag_o   = bf_q;
  assign addr_cnt_o    = addr_q;
  assign bus_owned_o   = own_q;
  assign lcd_data_oe_o = 1'b0;
  assign lcd_en_o      = en_q;
  assign lcd_rw_o      = rw_q;
  assign lcd_rs_o      = rs_q;

endmodule
